// File: rtl/aes_pkg.sv
// Shared AES constants and GF(2^8) helpers used by the encrypt core and, later, the decrypt path.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int AES_NR      = 10;

  typedef logic [1:0] aes_fsm_t;
  localparam aes_fsm_t FSM_IDLE = 2'd0;
  localparam aes_fsm_t FSM_RUN  = 2'd1;
  localparam aes_fsm_t FSM_DONE = 2'd2;

  // Round constant for key-expansion rounds 1..10; other indices are never used.
  function automatic logic [7:0] aes_rcon(input logic [3:0] rnd);
    logic [7:0] rc;
    case (rnd)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One MixColumns column; row 0 sits in bits [31:24].
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {b0, b1, b2, b3};
  endfunction

endpackage

// File: rtl/aes_sbox_fwd.sv
// Combinational 8-bit AES forward S-box (table lookup).
module aes_sbox_fwd (
  input  logic [7:0] a,
  output logic [7:0] y
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign y = SBOX[a];

endmodule

// File: rtl/aes128_encrypt_iter.sv
// Iterative AES-128 encryptor: one round per clock with on-the-fly key expansion.
// Optional round-10 key output enabled by defining AES_ENC_LASTKEY_EN.
module aes128_encrypt_iter
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_BLOCK_W-1:0] plaintext,
  input  logic [AES_BLOCK_W-1:0] key,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_BLOCK_W-1:0] ciphertext
`ifdef AES_ENC_LASTKEY_EN
  ,
  output logic [AES_BLOCK_W-1:0] last_key
`endif
);

  aes_fsm_t               fsm_q;
  logic [AES_BLOCK_W-1:0] state_q;
  logic [AES_BLOCK_W-1:0] rkey_q;
  logic [3:0]             round_q;

  logic [31:0]            rot_w;
  logic [31:0]            sub_w;
  logic [31:0]            nk0, nk1, nk2, nk3;
  logic [AES_BLOCK_W-1:0] next_rkey;
  logic [AES_BLOCK_W-1:0] sub_bytes;
  logic [AES_BLOCK_W-1:0] shifted;
  logic [AES_BLOCK_W-1:0] mixed;
  logic [AES_BLOCK_W-1:0] round_out;
  logic                   last_round;

  // Key schedule: the next round key depends only on the current one and the round index.
  assign rot_w = {rkey_q[23:0], rkey_q[31:24]};

  for (genvar k = 0; k < 4; k++) begin : g_key_sbox
    aes_sbox_fwd u_sbox (
      .a (rot_w[31-8*k -: 8]),
      .y (sub_w[31-8*k -: 8])
    );
  end

  assign nk0       = rkey_q[127:96] ^ sub_w ^ {aes_rcon(round_q), 24'h0};
  assign nk1       = rkey_q[95:64] ^ nk0;
  assign nk2       = rkey_q[63:32] ^ nk1;
  assign nk3       = rkey_q[31:0] ^ nk2;
  assign next_rkey = {nk0, nk1, nk2, nk3};

  for (genvar i = 0; i < 16; i++) begin : g_state_sbox
    aes_sbox_fwd u_sbox (
      .a (state_q[127-8*i -: 8]),
      .y (sub_bytes[127-8*i -: 8])
    );
  end

  // Byte i is row i%4, column i/4; row r rotates left by r columns.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign shifted[127-8*(4*c+r) -: 8] = sub_bytes[127-8*(4*((c+r)%4)+r) -: 8];
    end
    assign mixed[127-32*c -: 32] = mix_column(shifted[127-32*c -: 32]);
  end

  assign last_round = (round_q == 4'(NR));
  assign round_out  = (last_round ? shifted : mixed) ^ next_rkey;

  assign in_ready  = (fsm_q == FSM_IDLE);
  assign out_valid = (fsm_q == FSM_DONE);

  // Control and datapath registers; busy states ignore in_valid entirely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q      <= FSM_IDLE;
      state_q    <= '0;
      rkey_q     <= '0;
      round_q    <= '0;
      ciphertext <= '0;
`ifdef AES_ENC_LASTKEY_EN
      last_key   <= '0;
`endif
    end else begin
      case (fsm_q)
        FSM_IDLE: begin
          if (in_valid) begin
            state_q <= plaintext ^ key;
            rkey_q  <= key;
            round_q <= 4'd1;
            fsm_q   <= FSM_RUN;
          end
        end
        FSM_RUN: begin
          state_q <= round_out;
          rkey_q  <= next_rkey;
          round_q <= round_q + 4'd1;
          if (last_round) begin
            ciphertext <= round_out;
`ifdef AES_ENC_LASTKEY_EN
            last_key   <= next_rkey;
`endif
            fsm_q      <= FSM_DONE;
          end
        end
        FSM_DONE: begin
          if (out_ready) begin
            fsm_q <= FSM_IDLE;
          end
        end
        default: fsm_q <= FSM_IDLE;
      endcase
    end
  end

endmodule

// File: doc/aes128_encrypt_iter.md
Name: aes128_encrypt_iter

Overview:
- Iterative AES-128 encryption core; the encrypt-side counterpart of the team's inverse S-box and decryption datapath.
- Performs one full round per clock, with on-the-fly key expansion.
- Accepts one plaintext/key pair through a valid/ready handshake and returns the ciphertext through a valid/ready handshake.
- Sits beside the decrypt path in the AES top level; the optional last-round-key output feeds the decryptor's key schedule.

Parameters:
- NR, 10, number of AES rounds; fixed for AES-128, any other value is unsupported.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  plaintext and key are valid.
- in_ready  out  1  core can accept a block.
- plaintext  in  128  input block; bits [127:120] = byte 0 (row 0, col 0), column-major per FIPS-197.
- key  in  128  cipher key, same byte order.
- out_valid  out  1  ciphertext is valid.
- out_ready  in  1  downstream accepts the ciphertext.
- ciphertext  out  128  result block, same byte order.
- last_key  out  128  round-10 key; present only with AES_ENC_LASTKEY_EN.

Behaviour:
- Reset (asynchronous, rst_n low):
  - FSM goes to IDLE; in_ready=1, out_valid=0.
  - ciphertext=0, state register=0, round key register=0, round counter=0.
- FSM states IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: state <= plaintext ^ key, round key <= key, round counter <= 1, go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle: next round key = expand(round key, rcon[round counter]).
  - State <= MixColumns(ShiftRows(SubBytes(state))) ^ next round key.
  - Round counter increments.
  - When round counter == NR, MixColumns is skipped; result goes to ciphertext, go to DONE.
- DONE:
  - out_valid=1; ciphertext held stable.
  - On out_ready: out_valid drops next cycle, go to IDLE.
  - in_ready stays 0 in DONE; no new block is accepted until the output is consumed.
- Latency: acceptance edge to out_valid high = NR+1 = 11 rising edges. Throughput is one block per 12 cycles when out_ready is held high.
- Key expansion:
  - w0'=w0^SubWord(RotWord(w3))^{rcon,24'h0}.
  - w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
  - Rcon sequence 01,02,04,08,10,20,40,80,1b,36 for rounds 1..10.
- MixColumns uses GF(2^8) xtime with reduction polynomial 0x11b.
- Datapath uses 20 forward S-box instances: 16 for state, 4 for key.
- Boundary conditions:
  - in_valid while busy is ignored, not queued; inputs are sampled only on the accept edge.
  - Input changes during RUN have no effect.
  - rst_n asserted mid-RUN or mid-DONE aborts immediately; no out_valid follows.
  - out_ready high while out_valid low has no effect.

Optional Feature:
- Macro AES_ENC_LASTKEY_EN.
- Defined: port last_key exists. It is registered alongside ciphertext with the round-10 key, valid while out_valid=1, reset to 0.
- Undefined: port and register are absent; otherwise identical behaviour.

Decomposition:
- Shared package aes_pkg holds:
  - block/key width constant (128) and NR.
  - Rcon table.
  - FSM state enum.
  - xtime and MixColumns-column functions, reused later by the decrypt InvMixColumns.
- One sub-module aes_sbox_fwd: combinational 8-bit forward S-box, instantiated 20 times.

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> ct 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 11 edges after accept; with macro, last_key=13111d7fe3944a17f307a78b4d2b30c5.
- FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> ct 3925841d02dc09fbdc118597196a0b32; with macro, last_key=d014f9a8c9ee2589e13f0cc8b6630ca6.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> ciphertext stable, in_ready=0; pulse out_ready -> out_valid drops next cycle, in_ready=1.
- Busy ignore: pulse in_valid with a different block during RUN -> first result unchanged, no second out_valid.
- Reset mid-operation: drop rst_n at round 5 -> out_valid=0, in_ready=1, ciphertext=0 asynchronously; a fresh C.1 block afterwards yields the correct ct.
- Back-to-back: two blocks with out_ready tied 1 -> both cts correct, 12-cycle spacing between out_valid pulses.
